spi_master_ctrl: RTL and testbench

Parametrised SPI master, the next generation of the team's fixed 32-bit `spi` block. It adds configurable word width, all four SPI modes, a runtime clock divider, multiple decoded chip selects and a start/busy/done handshake. It sits between a host register interface and off-chip SPI peripherals. Each transfer shifts `din` out MSB-first while capturing `miso` into `dout`.

---
 rtl/spi_master_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: parametrised SPI master with four SPI modes, a runtime
// clock divider, decoded chip selects and a start/busy/done handshake.
// Each transfer shifts din out MSB-first on mosi while capturing miso into dout.
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-low reset
//   start   transfer request, accepted only while busy=0
//   din     transmit word, latched on accept
//   mode    {CPOL, CPHA}, latched on accept
//   div     half-period length minus one in clk cycles, latched on accept
//   cs_sel  target chip-select index, latched on accept
//   busy    transfer in progress
//   done    one-cycle pulse when dout is updated
//   dout    last received word
//   cs_n    active-low chip selects, one low while busy
//   sck     SPI clock
//   mosi    serial data out
//   miso    serial data in
module spi_master_ctrl #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned CS_W   = 2,
    parameter  int unsigned DIV_W  = 8,
    localparam int unsigned NUM_CS = 2 ** CS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  div,
    input  logic [CS_W-1:0]   cs_sel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic [NUM_CS-1:0] cs_n,
    output logic              sck,
    output logic              mosi,
    input  logic              miso
);

    // Phase index counts H-cycle phases: 0 is SETUP, 1..2*DATA_W are SHIFT.
    localparam int unsigned LAST_EDGE = 2 * DATA_W;
    localparam int unsigned EDGE_W    = $clog2(LAST_EDGE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    cnt;
    logic [EDGE_W-1:0]   edge_cnt;
    logic                cpha_q;
    logic [DATA_W-1:0]   tx_sr;
    logic [DATA_W-1:0]   rx_sr;

    logic                phase_end;
    logic                last_phase;
    logic                accept;
    logic                sck_edge;
    logic                lead;
    logic                capture;
    logic                drive;
    logic                finish;

    assign phase_end  = (state != IDLE) && (cnt == div_q);
    assign last_phase = (edge_cnt == EDGE_W'(LAST_EDGE));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                   state_nxt = SETUP;
            SETUP:   if (phase_end)               state_nxt = SHIFT;
            SHIFT:   if (phase_end && last_phase) state_nxt = HOLD;
            HOLD:    if (phase_end)               state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Per-cycle control strobes for the datapath
    always_comb begin
        accept   = 1'b0;
        sck_edge = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE:    accept   = start;
            SETUP:   sck_edge = phase_end;
            SHIFT:   sck_edge = phase_end && !last_phase;
            HOLD:    finish   = phase_end;
            default: ;
        endcase
        // Even phase index means the coming sck edge is a leading one.
        lead    = ~edge_cnt[0];
        capture = sck_edge && (lead ^ cpha_q);
        drive   = sck_edge && !(lead ^ cpha_q);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
            cs_n     <= '1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            div_q    <= '0;
            cnt      <= '0;
            edge_cnt <= '0;
            cpha_q   <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            done <= 1'b0;

            if (accept || phase_end) begin
                cnt <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + DIV_W'(1);
            end

            if (accept) begin
                busy     <= 1'b1;
                div_q    <= div;
                cpha_q   <= mode[0];
                sck      <= mode[1];
                cs_n     <= ~(NUM_CS'(1) << cs_sel);
                edge_cnt <= '0;
                rx_sr    <= '0;
                // CPHA=0 presents the MSB before the first edge.
                if (mode[0]) begin
                    mosi  <= 1'b0;
                    tx_sr <= din;
                end else begin
                    mosi  <= din[DATA_W-1];
                    tx_sr <= {din[DATA_W-2:0], 1'b0};
                end
            end

            if (sck_edge) begin
                sck      <= ~sck;
                edge_cnt <= edge_cnt + EDGE_W'(1);
            end

            if (capture) begin
                rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end

            if (drive) begin
                mosi  <= tx_sr[DATA_W-1];
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end

            if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
                dout <= rx_sr;
                cs_n <= '1;
                mosi <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: self-checking bench for spi_master_ctrl (DATA_W=8,
// four chip selects). A behavioural SPI slave follows sck/cs_n per mode and
// the expected timing is computed from H=div+1.
module tb_spi_master_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CS_W   = 2;
    localparam int unsigned DIV_W  = 8;
    localparam int unsigned NUM_CS = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] din;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  div;
    logic [CS_W-1:0]   cs_sel;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] dout;
    logic [NUM_CS-1:0] cs_n;
    logic              sck;
    logic              mosi;
    logic              miso;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // Current transfer context
    logic [7:0] x_din;
    logic [1:0] x_mode;
    int         x_h;
    int         x_sel;
    logic [7:0] x_exp_dout;
    logic [3:0] x_exp_cs;
    logic       loop_en = 1'b0;

    // Slave model and monitors
    logic [7:0] s_tx;
    logic [7:0] s_rx;
    logic       s_miso = 1'b0;
    logic       s_active;
    logic       prev_sck;
    int         n_edges;
    int         n_rise;
    int         last_edge;
    int         gap_bad;
    int         cs_bad;

    assign miso = loop_en ? mosi : s_miso;

    spi_master_ctrl #(
        .DATA_W (DATA_W),
        .CS_W   (CS_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .din    (din),
        .mode   (mode),
        .div    (div),
        .cs_sel (cs_sel),
        .busy   (busy),
        .done   (done),
        .dout   (dout),
        .cs_n   (cs_n),
        .sck    (sck),
        .mosi   (mosi),
        .miso   (miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave behaviour plus sck/cs_n observation, once per cycle.
    task automatic monitor_step();
        int   c;
        logic lead;
        c = cyc - acc_cyc;
        if (busy === 1'b1 && cs_n !== x_exp_cs) cs_bad++;
        if (sck !== prev_sck) begin
            n_edges++;
            if (sck === 1'b1) n_rise++;
            if (n_edges == 1) begin
                if (c != 1 + x_h) gap_bad++;
            end else if (c - last_edge != x_h) begin
                gap_bad++;
            end
            last_edge = c;
            lead = (sck !== x_mode[1]);
            if (lead ^ x_mode[0]) begin
                s_rx = {s_rx[6:0], mosi};
            end else begin
                s_miso = s_tx[7];
                s_tx   = {s_tx[6:0], 1'b0};
            end
        end
        prev_sck = sck;
        if (!s_active && cs_n[x_sel] === 1'b0) begin
            s_active = 1'b1;
            if (!x_mode[0]) begin
                s_miso = s_tx[7];
                s_tx   = {s_tx[6:0], 1'b0};
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
    endtask

    // Present a request at this negedge; returns at cycle 1 of the transfer.
    task automatic start_xfer(input logic [7:0] d, input int unsigned m, input int unsigned dv,
                              input int unsigned sel, input logic [7:0] sw, input logic lp);
        din        = d;
        mode       = 2'(m);
        div        = 8'(dv);
        cs_sel     = 2'(sel);
        start      = 1'b1;
        loop_en    = lp;
        x_din      = d;
        x_mode     = 2'(m);
        x_h        = int'(dv) + 1;
        x_sel      = int'(sel);
        x_exp_cs   = ~(4'b0001 << sel);
        x_exp_dout = lp ? d : sw;
        s_tx       = sw;
        s_rx       = 8'h00;
        s_miso     = 1'b0;
        s_active   = 1'b0;
        prev_sck   = x_mode[1];
        n_edges    = 0;
        n_rise     = 0;
        last_edge  = 0;
        gap_bad    = 0;
        cs_bad     = 0;
        acc_cyc    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_xfer(input logic early, input logic poke);
        int c;
        int d_exp;
        d_exp = 1 + x_h * (2 * DATA_W + 2);
        c = cyc - acc_cyc;
        check_eq("busy_c1", 32'(busy), 32'd1);
        check_eq("cs_c1", 32'(cs_n), 32'(x_exp_cs));
        check_eq("sck_c1", 32'(sck), 32'(x_mode[1]));
        if (!x_mode[0]) check_eq("mosi_msb", 32'(mosi), 32'(x_din[7]));
        while (done !== 1'b1 && c < d_exp + 8) begin
            if (poke) begin
                start = (c == 5);
                if (c == 5) begin
                    din    = ~din;
                    mode   = ~mode;
                    div    = 8'd0;
                    cs_sel = cs_sel + 2'd1;
                end
            end
            if (early && c == d_exp - 1) start = 1'b1;
            tick();
            c = cyc - acc_cyc;
        end
        check_eq("done_cycle", 32'(c), 32'(d_exp));
        check_eq("dout", 32'(dout), 32'(x_exp_dout));
        check_eq("busy_end", 32'(busy), 32'd0);
        check_eq("cs_end", 32'(cs_n), 32'hF);
        check_eq("mosi_end", 32'(mosi), 32'd0);
        check_eq("sck_idle", 32'(sck), 32'(x_mode[1]));
        check_eq("sck_edges", 32'(n_edges), 32'(2 * DATA_W));
        check_eq("sck_rises", 32'(n_rise), 32'(DATA_W));
        check_eq("sck_timing", 32'(gap_bad), 32'd0);
        check_eq("last_edge", 32'(last_edge), 32'(1 + x_h * 2 * DATA_W));
        check_eq("cs_during", 32'(cs_bad), 32'd0);
        check_eq("mosi_stream", 32'(s_rx), 32'(x_din));
        if (!early) begin
            tick();
            check_eq("done_pulse", 32'(done), 32'd0);
            check_eq("dout_hold", 32'(dout), 32'(x_exp_dout));
            check_eq("sck_idle2", 32'(sck), 32'(x_mode[1]));
        end
    endtask

    initial begin
        din    = '0;
        mode   = '0;
        div    = '0;
        cs_sel = '0;
        x_mode = 2'b00;
        x_sel  = 0;
        x_h    = 1;
        x_exp_cs = 4'hF;
        prev_sck = 1'b0;
        s_tx   = 8'h00;
        s_active = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_cs", 32'(cs_n), 32'hF);
        check_eq("rst_sck", 32'(sck), 32'd0);
        check_eq("rst_mosi", 32'(mosi), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Mode 0 loopback, div 0: done at cycle 19
        start_xfer(8'hA5, 0, 0, 0, 8'h00, 1'b1);
        finish_xfer(1'b0, 1'b0);

        // Mode 3, div 3
        start_xfer(8'hC3, 3, 3, 1, 8'h3C, 1'b0);
        finish_xfer(1'b0, 1'b0);

        // Modes 1 and 2
        start_xfer(8'h81, 1, 1, 0, 8'h7E, 1'b0);
        finish_xfer(1'b0, 1'b0);
        start_xfer(8'h81, 2, 2, 3, 8'h7E, 1'b0);
        finish_xfer(1'b0, 1'b0);

        // Start and input changes while busy are ignored
        start_xfer(8'h5A, 0, 1, 1, 8'h96, 1'b0);
        finish_xfer(1'b0, 1'b1);

        // Back-to-back with start held through done
        start_xfer(8'h12, 1, 0, 0, 8'hE7, 1'b0);
        finish_xfer(1'b1, 1'b0);
        start_xfer(8'h34, 2, 1, 3, 8'h18, 1'b0);
        finish_xfer(1'b0, 1'b0);

        // Only cs_n[2] low
        start_xfer(8'h6D, 0, 0, 2, 8'hB2, 1'b0);
        check_eq("cs_sel2", 32'(cs_n), 32'b1011);
        finish_xfer(1'b0, 1'b0);

        // Reset mid-transfer at cycle 7, then a clean transfer
        start_xfer(8'hF0, 3, 0, 1, 8'h0F, 1'b0);
        while (cyc - acc_cyc < 7) tick();
        rst = 1'b0;
        #1;
        check_eq("mid_rst_cs", 32'(cs_n), 32'hF);
        check_eq("mid_rst_sck", 32'(sck), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_dout", 32'(dout), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_mosi", 32'(mosi), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        start_xfer(8'h99, 3, 0, 1, 8'h66, 1'b0);
        finish_xfer(1'b0, 1'b0);

        // Randomised transfers
        repeat (16) begin
            start_xfer(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), 8'($urandom), 1'($urandom_range(0, 1)));
            finish_xfer(1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
